// File: rtl/otter_regfile_sb_if.sv
// Bus between the multicycle control FSM (master) and the scoreboarded register file (slave).
interface otter_regfile_sb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]   raddr;
  logic [NREAD*XLEN-1:0] rdata;
  logic [NREAD-1:0]      rpend;
  logic                  en;
  logic [AW-1:0]         waddr;
  logic [XLEN-1:0]       wd;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic                  ready;

  modport master (
    output raddr, en, waddr, wd, rsv_en, rsv_addr,
    input  rdata, rpend, ready
  );

  modport slave (
    input  raddr, en, waddr, wd, rsv_en, rsv_addr,
    output rdata, rpend, ready
  );
endinterface

// File: rtl/otter_regfile_sb.sv
// Parametrised register file with hardware clear sequencer and per-register pending scoreboard.
// Define OTTER_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module otter_regfile_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2
) (
  input logic               clk,
  input logic               rst,
  otter_regfile_sb_if.slave bus
);
  localparam int unsigned   AW      = $clog2(NREGS);
  localparam logic [AW-1:0] LastReg = AW'(NREGS - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             ready_q;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend_q;

  logic run;
  logic wr_ok;
  logic rsv_ok;

  assign run    = (state_q == StRun);
  assign wr_ok  = run && bus.en && (bus.waddr != '0);
  assign rsv_ok = run && bus.rsv_en && (bus.rsv_addr != '0);

  // Register 0 is never cleared: reads of address 0 are forced to zero instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (cnt_q == LastReg) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        StRun: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StClear;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      regs[cnt_q] <= '0;
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wd;
    end
  end

  // Later assignment wins, so a same-cycle reserve overrides the writeback clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      if (wr_ok) begin
        pend_q[bus.waddr] <= 1'b0;
      end
      if (rsv_ok) begin
        pend_q[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  logic [NREAD*XLEN-1:0] rdata_c;
  logic [NREAD-1:0]      rpend_c;

  always_comb begin
    rdata_c = '0;
    rpend_c = '0;
    if (run) begin
      for (int unsigned i = 0; i < NREAD; i++) begin
        if (bus.raddr[i*AW +: AW] != '0) begin
          rdata_c[i*XLEN +: XLEN] = regs[bus.raddr[i*AW +: AW]];
          rpend_c[i]              = pend_q[bus.raddr[i*AW +: AW]];
        end
`ifdef OTTER_RF_BYPASS_EN
        if (wr_ok && (bus.raddr[i*AW +: AW] == bus.waddr)) begin
          rdata_c[i*XLEN +: XLEN] = bus.wd;
          rpend_c[i]              = bus.rsv_en && (bus.rsv_addr == bus.waddr);
        end
`endif
      end
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.rpend = rpend_c;
  assign bus.ready = ready_q;
endmodule

// File: tb/tb_otter_regfile_sb.sv
// Directed bench for otter_regfile_sb: default 32x32x2 instance plus a 8x16x3 parameter sweep.
module tb_otter_regfile_sb;
  logic clk;
  logic rst;
  logic rst_s;
  int   checks;
  int   errors;

  otter_regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus ();
  otter_regfile_sb_if #(.XLEN(16), .NREGS(8), .NREAD(3)) bus_s ();

  otter_regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  otter_regfile_sb #(.XLEN(16), .NREGS(8), .NREAD(3)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until ready rises, bounded so a stuck sequencer cannot hang the run.
  task automatic count_edges(input bit sweep, output int n);
    n = 0;
    while (((sweep ? bus_s.ready : bus.ready) !== 1'b1) && (n < 60)) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic idle_main();
    bus.en     = 1'b0;
    bus.waddr  = '0;
    bus.wd     = '0;
    bus.rsv_en = 1'b0;
    bus.rsv_addr = '0;
  endtask

  int n;
  logic [31:0] exp_byp_d;
  logic        exp_byp_p;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rst_s  = 1'b1;
    idle_main();
    bus.raddr      = '0;
    bus_s.en       = 1'b0;
    bus_s.waddr    = '0;
    bus_s.wd       = '0;
    bus_s.rsv_en   = 1'b0;
    bus_s.rsv_addr = '0;
    bus_s.raddr    = '0;

    // Reset / clear with a write held on x5 throughout CLEAR
    bus.en    = 1'b1;
    bus.waddr = 5'd5;
    bus.wd    = 32'hDEAD_BEEF;
    bus.raddr = {5'd5, 5'd5};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_rpend", 64'(bus.rpend), 64'd0);
    chk("rst_ready_s", 64'(bus_s.ready), 64'd0);
    rst = 1'b0;
    count_edges(1'b0, n);
    chk("clear_edges", 64'(n), 64'd31);
    @(negedge clk);
    idle_main();
    #1;
    chk("x5_after_clear", 64'(bus.rdata), 64'd0);
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {2{5'(a)}};
      #1;
      chk($sformatf("clear_x%0d", a), 64'(bus.rdata), 64'd0);
    end

    // Basic write/read, including a discarded write to x0
    @(negedge clk);
    bus.en    = 1'b1;
    bus.waddr = 5'd7;
    bus.wd    = 32'h1234_5678;
    @(negedge clk);
    bus.waddr = 5'd0;
    bus.wd    = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_main();
    bus.raddr = {5'd0, 5'd7};
    #1;
    chk("rd_x7_x0", 64'(bus.rdata), {32'h0, 32'h1234_5678});

    // Scoreboard: reserve x0 (ignored), reserve x3, writeback, same-cycle reserve+write
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd0;
    @(negedge clk);
    bus.rsv_addr = 5'd3;
    @(negedge clk);
    idle_main();
    bus.raddr = {5'd0, 5'd3};
    #1;
    chk("pend_x3_set", 64'(bus.rpend), 64'b01);
    bus.en    = 1'b1;
    bus.waddr = 5'd3;
    bus.wd    = 32'h0000_00A5;
    @(negedge clk);
    idle_main();
    #1;
    chk("pend_x3_clr", 64'(bus.rpend), 64'b00);
    chk("rd_x3_a5", 64'(bus.rdata[31:0]), 64'h0000_00A5);
    bus.en       = 1'b1;
    bus.waddr    = 5'd3;
    bus.wd       = 32'h0000_005A;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd3;
    @(negedge clk);
    idle_main();
    #1;
    chk("pend_x3_setwins", 64'(bus.rpend), 64'b01);
    chk("rd_x3_5a", 64'(bus.rdata[31:0]), 64'h0000_005A);

    // Bypass: x9 holds 0x11 and is pending; new write of 0x55 observed before the edge
    bus.en    = 1'b1;
    bus.waddr = 5'd9;
    bus.wd    = 32'h0000_0011;
    @(negedge clk);
    idle_main();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd9;
    @(negedge clk);
    idle_main();
    bus.en    = 1'b1;
    bus.waddr = 5'd9;
    bus.wd    = 32'h0000_0055;
    bus.raddr = {5'd9, 5'd0};
`ifdef OTTER_RF_BYPASS_EN
    exp_byp_d = 32'h0000_0055;
    exp_byp_p = 1'b0;
`else
    exp_byp_d = 32'h0000_0011;
    exp_byp_p = 1'b1;
`endif
    #1;
    chk("byp_rdata", 64'(bus.rdata[63:32]), 64'(exp_byp_d));
    chk("byp_rpend", 64'(bus.rpend[1]), 64'(exp_byp_p));
    @(negedge clk);
    idle_main();
    #1;
    chk("x9_after_edge", 64'(bus.rdata[63:32]), 64'h0000_0055);
    chk("x9_pend_after", 64'(bus.rpend[1]), 64'd0);

    // Reset mid-operation
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd1;
    @(negedge clk);
    bus.rsv_addr = 5'd2;
    @(negedge clk);
    idle_main();
    bus.en    = 1'b1;
    bus.waddr = 5'd4;
    bus.wd    = 32'd7;
    @(negedge clk);
    idle_main();
    bus.raddr = {5'd2, 5'd1};
    #1;
    chk("pend_x1_x2", 64'(bus.rpend), 64'b11);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(bus.ready), 64'd0);
    chk("midrst_rpend", 64'(bus.rpend), 64'd0);
    chk("midrst_rdata", 64'(bus.rdata), 64'd0);
    #1;
    rst = 1'b0;
    count_edges(1'b0, n);
    chk("reclear_edges", 64'(n), 64'd31);
    @(negedge clk);
    bus.raddr = {5'd1, 5'd4};
    #1;
    chk("x4_after_reclear", 64'(bus.rdata[31:0]), 64'd0);
    chk("pend_after_reclear", 64'(bus.rpend), 64'd0);

    // Parameter sweep: NREGS=8, NREAD=3, XLEN=16
    rst_s = 1'b0;
    count_edges(1'b1, n);
    chk("sweep_clear_edges", 64'(n), 64'd7);
    @(negedge clk);
    for (int a = 1; a < 8; a++) begin
      bus_s.en    = 1'b1;
      bus_s.waddr = 3'(a);
      bus_s.wd    = 16'(a);
      @(negedge clk);
    end
    bus_s.en    = 1'b0;
    bus_s.raddr = {3'd0, 3'd7, 3'd7};
    #1;
    chk("sweep_rd_7_7_0", 64'(bus_s.rdata), 64'({16'd0, 16'd7, 16'd7}));
    bus_s.raddr = {3'd1, 3'd3, 3'd5};
    #1;
    chk("sweep_rd_5_3_1", 64'(bus_s.rdata), 64'({16'd1, 16'd3, 16'd5}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
